// File: rtl/stream_fifo_pkg.sv
// Shared constants for the stream stages.
//
// STREAM_WIDTH / STREAM_DEPTH are the default word width and buffer depth
// used by the stream stages. ptr_width() returns the number of address bits
// needed to index a power-of-two buffer of the given depth.
package stream_fifo_pkg;

  localparam int STREAM_WIDTH = 16;
  localparam int STREAM_DEPTH = 8;

  // Address bits for a power-of-two depth (depth >= 2).
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Storage array for stream_fifo.
//
// One synchronous write port and one asynchronous read port. There is no
// reset: contents are meaningless until written, and the control logic never
// presents an unwritten word as valid.
//
// Ports:
//   clk    rising-edge clock for the write port
//   we     write enable
//   waddr  write address (AW bits)
//   wdata  write data (WIDTH bits)
//   raddr  read address (AW bits)
//   rdata  read data, combinational from raddr
module stream_fifo_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Synchronous stream FIFO with strobe/acknowledge handshakes on both sides.
//
// Handshake: a word moves across a port on a rising clock edge where that
// port's stb and ack are both high. stb may be held with ack low for any
// number of cycles without consuming anything. Both acks/strobes driven by
// this block (input_a_ack, output_z_stb) and output_z come from registered
// state only, so no input reaches any output combinationally; a word
// written into an empty FIFO becomes visible only after the write edge.
//
// The whole control state is the (write pointer, read pointer, count)
// triple; there is no separate state machine.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous, active-low reset; clears pointers and count
//   input_a       upstream data word
//   input_a_stb   upstream data valid
//   input_a_ack   high while there is room (count != DEPTH)
//   output_z      word at the read pointer (don't-care while output_z_stb low)
//   output_z_stb  high while the FIFO holds data (count != 0)
//   output_z_ack  downstream takes output_z this cycle
//   count         number of words stored, 0..DEPTH
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = STREAM_WIDTH,
  // Must be a power of two, at least 2, so the pointers wrap naturally.
  parameter int DEPTH = STREAM_DEPTH,
  localparam int AW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  output logic [WIDTH-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;

  // Flow-control outputs depend on the registered count only.
  assign input_a_ack  = (count != FULL_COUNT);
  assign output_z_stb = (count != '0);

  assign wr_fire = input_a_stb  & input_a_ack;
  assign rd_fire = output_z_stb & output_z_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so DEPTH-1 + 1 wraps to 0.
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Writes are suppressed while reset is held so nothing lands in storage
  // on an edge that coincides with reset.
  stream_fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire & rst),
    .waddr (wr_ptr),
    .wdata (input_a),
    .raddr (rd_ptr),
    .rdata (output_z)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo.
//
// Inputs change 1 time unit after each rising edge; outputs are compared on
// the falling edge against a queue model (exp_q) that holds exactly the words
// the FIFO should contain. Words taken downstream are logged in rx_q so the
// directed sections can compare them with literal expected sequences.
module tb_stream_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int RAND_WORDS = 10000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT ----------------
  logic [WIDTH-1:0] input_a = '0;
  logic             input_a_stb = 1'b0;
  logic             input_a_ack;
  logic [WIDTH-1:0] output_z;
  logic             output_z_stb;
  logic             output_z_ack = 1'b0;
  logic [CW-1:0]    count;

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .count        (count)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] rx_q[$];
  int wr_total = 0;
  int rd_total = 0;
  int max_count = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a word enters when stb is high and the queue has room,
  // leaves when ack is high and the queue is non-empty, all decided on the
  // contents before the edge. Reset empties it at once.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      logic do_wr, do_rd;
      do_wr = input_a_stb && (exp_q.size() != DEPTH);
      do_rd = output_z_ack && (exp_q.size() != 0);
      if (do_rd) begin
        void'(exp_q.pop_front());
        rd_total++;
      end
      if (do_wr) begin
        exp_q.push_back(input_a);
        wr_total++;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_z = '0;
  always @(negedge clk) begin
    if (rst) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("input_a_ack", 32'(input_a_ack), 32'(exp_q.size() != DEPTH));
      chk("output_z_stb", 32'(output_z_stb), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("output_z", 32'(output_z), 32'(exp_q[0]));
      end
      if (prev_stall) begin
        chk("output_z_stable", 32'(output_z), 32'(prev_z));
      end
      if (int'(count) > max_count) max_count = int'(count);
      if (exp_q.size() != 0 && output_z_ack) rx_q.push_back(output_z);
      prev_stall = (exp_q.size() != 0) && !output_z_ack;
      prev_z     = output_z;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stb, input logic [WIDTH-1:0] d, input logic ack);
    input_a_stb  = stb;
    input_a      = d;
    output_z_ack = ack;
  endtask

  task automatic fill(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + WIDTH'(i), 1'b0);
      cyc();
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int n);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < n; i++) cyc();
    drive(1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] cur;
    int cycles;
    int last_wr;

    // Reset and release between edges.
    repeat (3) @(posedge clk);
    #3;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_z_stb", 32'(output_z_stb), 32'd0);
    rst = 1'b1;
    #1;
    chk("reset_a_ack", 32'(input_a_ack), 32'd1);
    cyc();

    // Fill with 0x0001..0x0008, no draining; first word not visible before its edge.
    drive(1'b1, 16'h0001, 1'b0);
    #1;
    chk("empty_no_bypass", 32'(output_z_stb), 32'd0);
    cyc();
    chk("first_word_visible", 32'(output_z_stb), 32'd1);
    chk("first_word_value", 32'(output_z), 32'h0001);
    for (int i = 2; i <= 8; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      cyc();
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_a_ack", 32'(input_a_ack), 32'd0);
    drive(1'b1, 16'h0009, 1'b0);
    repeat (3) cyc();
    chk("ninth_not_taken", 32'(count), 32'd8);

    // Drain with ack held high: eight words on eight consecutive edges.
    rx_q.delete();
    drain(8);
    chk("drain_rx_count", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      chk("drain_order", 32'(rx_q[i]), 32'(i + 1));
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_z_stb", 32'(output_z_stb), 32'd0);

    // Full with both strobes on the same edge: one out, none in.
    fill(16'h00A0, 8);
    rx_q.delete();
    drive(1'b1, 16'h00FF, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b0);
    chk("full_both_count", 32'(count), 32'd7);
    chk("full_both_a_ack", 32'(input_a_ack), 32'd1);
    chk("full_both_out", 32'(rx_q.size() > 0 ? rx_q[0] : 16'hDEAD), 32'h00A0);
    drain(7);
    chk("full_both_rx_count", 32'(rx_q.size()), 32'd8);
    for (int i = 1; i < 8 && i < rx_q.size(); i++) begin
      chk("full_both_order", 32'(rx_q[i]), 32'(16'h00A0 + i));
    end

    // Streaming 40 words with stb and ack both held high.
    rx_q.delete();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 16'h1000 + WIDTH'(i), 1'b1);
      cyc();
      chk("stream_count", 32'(count), 32'd1);
    end
    drain(1);
    chk("stream_rx_count", 32'(rx_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      chk("stream_order", 32'(rx_q[i]), 32'(16'h1000 + i));
    end

    // Partial-cycle reset with five words stored and both strobes active.
    fill(16'h0050, 5);
    chk("pre_reset_count", 32'(count), 32'd5);
    drive(1'b1, 16'h0055, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_z_stb", 32'(output_z_stb), 32'd0);
    #2;
    rst = 1'b1;
    rx_q.delete();
    cyc();
    drive(1'b0, '0, 1'b1);
    repeat (2) cyc();
    drive(1'b0, '0, 1'b0);
    chk("post_reset_rx_count", 32'(rx_q.size()), 32'd1);
    chk("post_reset_first", 32'(rx_q.size() > 0 ? rx_q[0] : 16'hDEAD), 32'h0055);

    // Random stalls on both sides.
    wr_total = 0;
    rd_total = 0;
    max_count = 0;
    cur = WIDTH'($urandom);
    last_wr = 0;
    cycles = 0;
    while (wr_total < RAND_WORDS && cycles < 60000) begin
      if (wr_total != last_wr) begin
        cur = WIDTH'($urandom);
        last_wr = wr_total;
      end
      drive(1'($urandom_range(0, 1)), cur, 1'($urandom_range(0, 1)));
      cyc();
      cycles++;
    end
    chk("rand_all_written", 32'(wr_total), 32'(RAND_WORDS));
    drive(1'b0, '0, 1'b1);
    cycles = 0;
    while (count != '0 && cycles < 20) begin
      cyc();
      cycles++;
    end
    drive(1'b0, '0, 1'b0);
    cyc();
    chk("rand_all_read", 32'(rd_total), 32'(RAND_WORDS));
    chk("rand_final_count", 32'(count), 32'd0);
    chk("rand_max_count_le_8", 32'(max_count <= DEPTH), 32'd1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
